// File: rtl/bq_pkg.sv
// bq_pkg
//   Shared constants and types for the biquad MAC scheduler.
//   DW/CW/FRAC/ACCW : sample, coefficient, fraction and accumulator widths.
//   state_t         : sequencing FSM states.
//   TAP_*           : tap index encoding used by the MAC operand mux.
//   SAT_MAX/SAT_MIN : output clip bounds for a DW-bit signed sample.
package bq_pkg;

  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int FRAC = 14;
  localparam int ACCW = DW + CW + 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    ROUND,
    OUT
  } state_t;

  localparam logic [2:0] TAP_B0 = 3'd0;
  localparam logic [2:0] TAP_B1 = 3'd1;
  localparam logic [2:0] TAP_B2 = 3'd2;
  localparam logic [2:0] TAP_A1 = 3'd3;
  localparam logic [2:0] TAP_A2 = 3'd4;

  localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

endpackage

// File: rtl/bq_mac.sv
// bq_mac
//   Single signed multiplier feeding an ACCW-bit accumulator, plus the
//   combinational round-half-up / saturate stage that turns the
//   accumulator into an output sample.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     acc_clr   : zero the accumulator on the next edge
//     acc_en    : accumulate the current product on the next edge
//     acc_sub   : subtract instead of add (feedback taps)
//     sample    : signed DW-bit multiplier operand
//     coef      : signed CW-bit coefficient operand
//     result    : rounded and saturated accumulator value
//     sat       : result was clipped
module bq_mac
  import bq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 acc_clr,
  input  logic                 acc_en,
  input  logic                 acc_sub,
  input  logic signed [DW-1:0] sample,
  input  logic signed [CW-1:0] coef,
  output logic signed [DW-1:0] result,
  output logic                 sat
);

  localparam logic signed [ACCW:0] HALF =
    {{(ACCW-FRAC+1){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

  logic signed [DW+CW-1:0]    prod;
  logic signed [ACCW-1:0]     prod_ext;
  logic signed [ACCW-1:0]     acc;
  logic signed [ACCW:0]       biased;
  logic signed [ACCW-FRAC:0]  shifted;
  logic [ACCW-FRAC-DW+1:0]    hi_bits;
  logic                       unused_round_bits;

  assign prod     = sample * coef;
  assign prod_ext = {{(ACCW-DW-CW){prod[DW+CW-1]}}, prod};

  always_ff @(posedge clk) begin
    if (rst || acc_clr) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= acc_sub ? (acc - prod_ext) : (acc + prod_ext);
    end
  end

  // One extra bit on the bias add so the half-LSB can never wrap the top.
  // Taking the upper bits of the biased sum is the arithmetic shift.
  assign biased            = {acc[ACCW-1], acc} + HALF;
  assign shifted           = biased[ACCW:FRAC];
  assign hi_bits           = shifted[ACCW-FRAC:DW-1];
  assign unused_round_bits = ^biased[FRAC-1:0];

  // The value fits in DW bits only if every bit above the DW-1 sign
  // position is a copy of it.
  always_comb begin
    result = shifted[DW-1:0];
    sat    = 1'b0;
    if (!((&hi_bits) || (~|hi_bits))) begin
      sat    = 1'b1;
      result = shifted[ACCW-FRAC] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/bq_mac_sched.sv
// bq_mac_sched
//   Sequencing controller for a direct-form-I biquad. Accepts one sample
//   per handshake, steps the shared MAC through the five taps, rounds and
//   saturates, and shifts the delay line.
//   Ports:
//     wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//     x_valid_i, x_i     : input sample handshake and data
//     x_ready_o          : high only while idle
//     coef_i             : {a2,a1,b2,b1,b0}, b0 in the LSBs
//     clr_i              : clear the delay line / abort current sample
//     y_o, y_valid_o     : output sample and its one-cycle strobe
//     busy_o             : computation in progress
//     sat_o              : sticky saturation flag
module bq_mac_sched
  import bq_pkg::*;
(
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            x_valid_i,
  input  logic [DW-1:0]   x_i,
  output logic            x_ready_o,
  input  logic [5*CW-1:0] coef_i,
  input  logic            clr_i,
  output logic [DW-1:0]   y_o,
  output logic            y_valid_o,
  output logic            busy_o,
  output logic            sat_o
);

  state_t state;
  logic [2:0] tap;

  logic [5*CW-1:0]     coef_q;
  logic signed [DW-1:0] x_cur, x1, x2, y1, y2;
  logic signed [CW-1:0] b0_q, b1_q, b2_q, a1_q, a2_q;

  logic                 mac_clr, mac_en, mac_sub, mac_sat;
  logic signed [DW-1:0] mac_sample, mac_result;
  logic signed [CW-1:0] mac_coef;

  assign b0_q = coef_q[0*CW +: CW];
  assign b1_q = coef_q[1*CW +: CW];
  assign b2_q = coef_q[2*CW +: CW];
  assign a1_q = coef_q[3*CW +: CW];
  assign a2_q = coef_q[4*CW +: CW];

  // Abort also flushes the accumulator so nothing leaks into the next sample.
  assign mac_clr = (state == LOAD) || clr_i;
  assign mac_en  = (state == MAC) && !clr_i;

  always_comb begin
    mac_sample = x_cur;
    mac_coef   = b0_q;
    mac_sub    = 1'b0;
    case (tap)
      TAP_B0: begin
        mac_sample = x_cur;
        mac_coef   = b0_q;
      end
      TAP_B1: begin
        mac_sample = x1;
        mac_coef   = b1_q;
      end
      TAP_B2: begin
        mac_sample = x2;
        mac_coef   = b2_q;
      end
      TAP_A1: begin
        mac_sample = y1;
        mac_coef   = a1_q;
        mac_sub    = 1'b1;
      end
      default: begin
        mac_sample = y2;
        mac_coef   = a2_q;
        mac_sub    = 1'b1;
      end
    endcase
  end

  bq_mac u_mac (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .acc_clr (mac_clr),
    .acc_en  (mac_en),
    .acc_sub (mac_sub),
    .sample  (mac_sample),
    .coef    (mac_coef),
    .result  (mac_result),
    .sat     (mac_sat)
  );

  // Sample and coefficients are captured on the accept edge itself, so the
  // producer and coefficient source are free to change from LOAD onwards.
  // The result is registered on the ROUND->OUT edge, which makes y_valid_o
  // and the shifted delay line visible during OUT.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      tap       <= TAP_B0;
      x_ready_o <= 1'b1;
      busy_o    <= 1'b0;
      y_o       <= '0;
      y_valid_o <= 1'b0;
      sat_o     <= 1'b0;
      x_cur     <= '0;
      coef_q    <= '0;
      x1        <= '0;
      x2        <= '0;
      y1        <= '0;
      y2        <= '0;
    end else begin
      y_valid_o <= 1'b0;
      if (clr_i) begin
        state     <= IDLE;
        tap       <= TAP_B0;
        x_ready_o <= 1'b1;
        busy_o    <= 1'b0;
        sat_o     <= 1'b0;
        x1        <= '0;
        x2        <= '0;
        y1        <= '0;
        y2        <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (x_valid_i && x_ready_o) begin
              x_cur     <= x_i;
              coef_q    <= coef_i;
              state     <= LOAD;
              x_ready_o <= 1'b0;
              busy_o    <= 1'b1;
            end
          end
          LOAD: begin
            tap   <= TAP_B0;
            state <= MAC;
          end
          MAC: begin
            if (tap == TAP_A2) begin
              state <= ROUND;
            end else begin
              tap <= tap + 3'd1;
            end
          end
          ROUND: begin
            y_o       <= mac_result;
            y_valid_o <= 1'b1;
            if (mac_sat) begin
              sat_o <= 1'b1;
            end
            x2    <= x1;
            x1    <= x_cur;
            y2    <= y1;
            y1    <= mac_result;
            state <= OUT;
          end
          OUT: begin
            state     <= IDLE;
            x_ready_o <= 1'b1;
            busy_o    <= 1'b0;
          end
          default: begin
            state     <= IDLE;
            x_ready_o <= 1'b1;
            busy_o    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bq_mac_sched.sv
module tb_bq_mac_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        x_valid;
  logic [15:0] x_in;
  logic        x_ready;
  logic [79:0] coef;
  logic        clr;
  logic [15:0] y;
  logic        y_valid;
  logic        busy;
  logic        sat;

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;

  bq_mac_sched dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .x_valid_i (x_valid),
    .x_i       (x_in),
    .x_ready_o (x_ready),
    .coef_i    (coef),
    .clr_i     (clr),
    .y_o       (y),
    .y_valid_o (y_valid),
    .busy_o    (busy),
    .sat_o     (sat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  function automatic logic [79:0] mkCoef(input logic [15:0] b0, input logic [15:0] b1,
                                         input logic [15:0] b2, input logic [15:0] a1,
                                         input logic [15:0] a2);
    return {a2, a1, b2, b1, b0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits for ready, presents x for one accept edge; returns at the
  // falling edge of the cycle after accept (first LOAD cycle).
  task automatic applyStimulus(input logic [15:0] x);
    int guard = 0;
    while (!x_ready && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("ready_wait", x_ready, 1'b1);
    x_valid = 1'b1;
    x_in    = x;
    @(negedge clk);
    x_valid = 1'b0;
    checkOutput("busy_after_accept", busy, 1'b1);
  endtask

  task automatic awaitOutput(input string tag, input logic [15:0] exp_y, input int start_n);
    int n = start_n;
    while (!y_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"}, y_valid, 1'b1);
    checkOutput({tag, "_latency"}, n, 8);
    checkOutput({tag, "_y"}, y, exp_y);
    @(negedge clk);
    checkOutput({tag, "_pulse"}, y_valid, 1'b0);
  endtask

  task automatic clrPulse();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"}, x_ready, 1'b1);
    checkOutput({tag, "_y"}, y, 16'h0000);
    checkOutput({tag, "_yvalid"}, y_valid, 1'b0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_sat"}, sat, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] bp_vals [3];
    int last_acc;
    int n;
    int got;
    logic [15:0] yv;

    bp_vals = '{16'h0123, 16'hFBAA, 16'h1FFF};
    rst = 1'b1; x_valid = 1'b0; x_in = '0; clr = 1'b0;
    coef = mkCoef(16'h4000, 16'h0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkResetState("reset");

    // Impulse through b0 = 1.0
    applyStimulus(16'h1000);
    checkOutput("imp_ready_low", x_ready, 1'b0);
    awaitOutput("imp0", 16'h1000, 1);
    applyStimulus(16'h0000);
    awaitOutput("imp1", 16'h0000, 1);

    // clr in IDLE wins over a simultaneous valid
    x_valid = 1'b1; x_in = 16'h7777;
    clrPulse();
    x_valid = 1'b0;
    checkOutput("clr_prio_busy", busy, 1'b0);
    checkOutput("clr_prio_ready", x_ready, 1'b1);

    // Recursive decay, a1 = -0.5
    coef = mkCoef(16'h4000, 16'h0, 16'h0, 16'hE000, 16'h0);
    applyStimulus(16'h2000); awaitOutput("dec0", 16'h2000, 1);
    applyStimulus(16'h0000); awaitOutput("dec1", 16'h1000, 1);
    applyStimulus(16'h0000); awaitOutput("dec2", 16'h0800, 1);
    applyStimulus(16'h0000); awaitOutput("dec3", 16'h0400, 1);

    // Positive saturation
    clrPulse();
    coef = mkCoef(16'h7FFF, 16'h7FFF, 16'h0, 16'h0, 16'h0);
    applyStimulus(16'h7FFF); awaitOutput("satp0", 16'h7FFF, 1);
    checkOutput("satp0_flag", sat, 1'b1);
    applyStimulus(16'h7FFF); awaitOutput("satp1", 16'h7FFF, 1);
    checkOutput("satp1_flag", sat, 1'b1);

    // Negative saturation, flag cleared by clr first
    clrPulse();
    checkOutput("sat_cleared", sat, 1'b0);
    applyStimulus(16'h8000); awaitOutput("satn0", 16'h8000, 1);
    applyStimulus(16'h8000); awaitOutput("satn1", 16'h8000, 1);
    checkOutput("satn_flag", sat, 1'b1);

    // Backpressure: valid held high across three samples
    clrPulse();
    coef = mkCoef(16'h4000, 16'h0, 16'h0, 16'h0, 16'h0);
    x_valid = 1'b1;
    last_acc = 0;
    for (int i = 0; i < 3; i++) begin
      x_in = bp_vals[i];
      n = 0;
      while (!x_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (i > 0) checkOutput("bp_interval", cycle_cnt - last_acc, 9);
      last_acc = cycle_cnt;
      @(negedge clk);
      n = 0; got = 0; yv = '0;
      while (!x_ready && n < 20) begin
        if (y_valid) begin
          got++;
          yv = y;
        end
        @(negedge clk);
        n++;
      end
      if (i == 2) x_valid = 1'b0;
      checkOutput("bp_ready_low", n, 8);
      checkOutput("bp_one_output", got, 1);
      checkOutput("bp_y", yv, bp_vals[i]);
    end

    // Coefficient snapshot
    clrPulse();
    applyStimulus(16'h1000);
    @(negedge clk);
    @(negedge clk);
    coef = mkCoef(16'h2000, 16'h0, 16'h0, 16'h0, 16'h0);
    awaitOutput("snap_old", 16'h1000, 3);
    applyStimulus(16'h1000);
    awaitOutput("snap_new", 16'h0800, 1);

    // Abort with clr mid-computation; prime delay line first
    clrPulse();
    coef = mkCoef(16'h4000, 16'h0, 16'h0, 16'hE000, 16'h0);
    applyStimulus(16'h2000); awaitOutput("abort_prime", 16'h2000, 1);
    applyStimulus(16'h0000);
    @(negedge clk); @(negedge clk);
    clrPulse();
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_ready", x_ready, 1'b1);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      if (y_valid) got++;
      @(negedge clk);
    end
    checkOutput("abort_no_valid", got, 0);
    applyStimulus(16'h2000); awaitOutput("abort_fresh0", 16'h2000, 1);
    applyStimulus(16'h0000); awaitOutput("abort_fresh1", 16'h1000, 1);

    // Abort with reset mid-computation
    applyStimulus(16'h2000);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkResetState("rst_abort");
    got = 0;
    for (int i = 0; i < 10; i++) begin
      if (y_valid) got++;
      @(negedge clk);
    end
    checkOutput("rst_no_valid", got, 0);
    coef = mkCoef(16'h4000, 16'h0, 16'h0, 16'hE000, 16'h0);
    applyStimulus(16'h2000); awaitOutput("rst_fresh0", 16'h2000, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
